// File: rtl/multi_dice_roller.sv
// Multi-die roller: debounced button starts a roll, per-die LFSRs tumble the faces,
// then a slow-down phase settles them and a one-cycle result pulse is issued.
module multi_dice_roller #(
  parameter int DICE_MAX        = 6,
  parameter int NUM_DICE        = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int ROLL_CYCLES     = 32,
  parameter int SETTLE_CYCLES   = 16,
  localparam int BIT_WIDTH      = $clog2(DICE_MAX + 1),
  localparam int SUM_WIDTH      = $clog2(NUM_DICE * DICE_MAX + 1)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          button,
  input  logic                          mode,
  output logic [NUM_DICE*BIT_WIDTH-1:0] dice_values,
  output logic [SUM_WIDTH-1:0]          dice_sum,
  output logic                          result_valid,
  output logic                          rolling,
  output logic [15:0]                   roll_count
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int PH_MAX = (ROLL_CYCLES > SETTLE_CYCLES) ? ROLL_CYCLES : SETTLE_CYCLES;
  localparam int CNT_W  = $clog2(PH_MAX + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ROLLING = 2'd1,
    S_SETTLE  = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  // Fibonacci LFSR, taps 16,14,13,11, right shift with feedback entering bit 15
  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
  endfunction

  function automatic logic [BIT_WIDTH-1:0] face(input logic [15:0] l);
    return BIT_WIDTH'((l % 16'(DICE_MAX)) + 16'd1);
  endfunction

  state_t                        state_q, state_d;
  logic                          sync1_q, sync2_q;
  logic                          btn_db_q, btn_db_d, btn_prev_q;
  logic [DB_W-1:0]               db_cnt_q, db_cnt_d;
  logic                          mode_q, mode_d;
  logic [CNT_W-1:0]              ph_q, ph_d;
  logic [15:0]                   lfsr_q [NUM_DICE];
  logic [NUM_DICE*BIT_WIDTH-1:0] dice_q;
  logic [SUM_WIDTH-1:0]          sum_q, sum_d;
  logic                          valid_q, rolling_q;
  logic [15:0]                   count_q;
  logic                          press_s, release_s, adv_s, upd_s, done_s;

  assign press_s   =  btn_db_q & ~btn_prev_q;
  assign release_s = ~btn_db_q &  btn_prev_q;

  // Debounce: accept the synchronised level only after DEBOUNCE_CYCLES of disagreement
  always_comb begin
    btn_db_d = btn_db_q;
    db_cnt_d = '0;
    if (sync2_q != btn_db_q) begin
      if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        btn_db_d = sync2_q;
        db_cnt_d = '0;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end else begin
      db_cnt_d = '0;
    end
  end

  // Roll sequencing: next state, phase counter and dice advance/update strobes
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    ph_d    = ph_q;
    adv_s   = 1'b0;
    upd_s   = 1'b0;
    done_s  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (press_s) begin
          state_d = S_ROLLING;
          mode_d  = mode;
          ph_d    = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ROLLING: begin
        adv_s = 1'b1;
        upd_s = 1'b1;
        ph_d  = ph_q + 1'b1;
        if (mode_q ? (ph_q == CNT_W'(ROLL_CYCLES - 1)) : release_s) begin
          state_d = S_SETTLE;
          ph_d    = '0;
        end else begin
          state_d = S_ROLLING;
        end
      end
      S_SETTLE: begin
        adv_s = 1'b1;
        upd_s = (ph_q[1:0] == 2'b00);
        ph_d  = ph_q + 1'b1;
        if (ph_q == CNT_W'(SETTLE_CYCLES - 1)) begin
          state_d = S_DONE;
          ph_d    = '0;
          done_s  = 1'b1;
        end else begin
          state_d = S_SETTLE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Sum of the currently presented dice, registered one cycle later
  always_comb begin
    sum_d = '0;
    for (int i = 0; i < NUM_DICE; i++) begin
      sum_d = sum_d + SUM_WIDTH'(dice_q[i*BIT_WIDTH +: BIT_WIDTH]);
    end
  end

  // Control, button pipeline and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      btn_db_q   <= 1'b0;
      btn_prev_q <= 1'b0;
      db_cnt_q   <= '0;
      mode_q     <= 1'b0;
      ph_q       <= '0;
      sum_q      <= SUM_WIDTH'(NUM_DICE);
      valid_q    <= 1'b0;
      rolling_q  <= 1'b0;
      count_q    <= 16'd0;
    end else begin
      state_q    <= state_d;
      sync1_q    <= button;
      sync2_q    <= sync1_q;
      btn_db_q   <= btn_db_d;
      btn_prev_q <= btn_db_q;
      db_cnt_q   <= db_cnt_d;
      mode_q     <= mode_d;
      ph_q       <= ph_d;
      sum_q      <= sum_d;
      valid_q    <= done_s;
      rolling_q  <= (state_d == S_ROLLING) || (state_d == S_SETTLE);
      count_q    <= count_q + {15'd0, done_s};
    end
  end

  // Per-die LFSRs and face registers; faces sample the pre-shift LFSR value
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_DICE; i++) begin
        lfsr_q[i]                          <= 16'(i + 1);
        dice_q[i*BIT_WIDTH +: BIT_WIDTH]   <= BIT_WIDTH'(1);
      end
    end else begin
      for (int i = 0; i < NUM_DICE; i++) begin
        if (adv_s) lfsr_q[i] <= lfsr_step(lfsr_q[i]);
        if (upd_s) dice_q[i*BIT_WIDTH +: BIT_WIDTH] <= face(lfsr_q[i]);
      end
    end
  end

  assign dice_values  = dice_q;
  assign dice_sum     = sum_q;
  assign result_valid = valid_q;
  assign rolling      = rolling_q;
  assign roll_count   = count_q;

endmodule

// File: tb/tb_multi_dice_roller.sv
// Scoreboard bench: a bench-side LFSR model predicts each final roll, queued at press time
// and compared when result_valid pulses. A second instance covers 4 x d20 over 1000 rolls.
module tb_multi_dice_roller;

  logic        clk = 1'b0;
  logic        reset, button, mode, button_b;
  logic        mode_b = 1'b1;
  logic [5:0]  dv;
  logic [3:0]  ds;
  logic        rv, rl;
  logic [15:0] rc;
  logic [19:0] dv_b;
  logic [6:0]  ds_b;
  logic        rv_b, rl_b;
  logic [15:0] rc_b;

  int tests = 0;
  int fails = 0;

  typedef struct { logic [19:0] dice; logic [15:0] cnt; } exp_t;
  exp_t        qa[$];
  exp_t        qb[$];
  logic [15:0] ma [2];
  logic [15:0] mb [4];
  int          cnt_a = 0;
  int          cnt_b = 0;

  always #5 clk = ~clk;

  multi_dice_roller dut (
    .clk(clk), .reset(reset), .button(button), .mode(mode),
    .dice_values(dv), .dice_sum(ds), .result_valid(rv), .rolling(rl), .roll_count(rc)
  );

  multi_dice_roller #(.DICE_MAX(20), .NUM_DICE(4), .DEBOUNCE_CYCLES(1),
                      .ROLL_CYCLES(4), .SETTLE_CYCLES(4)) dut_b (
    .clk(clk), .reset(reset), .button(button_b), .mode(mode_b),
    .dice_values(dv_b), .dice_sum(ds_b), .result_valid(rv_b), .rolling(rl_b), .roll_count(rc_b)
  );

  function automatic logic [15:0] adv(input logic [15:0] l, input int n);
    logic [15:0] x;
    x = l;
    for (int k = 0; k < n; k++) x = {x[0] ^ x[2] ^ x[3] ^ x[5], x[15:1]};
    return x;
  endfunction

  function automatic logic [4:0] face(input logic [15:0] l, input int m);
    logic [15:0] r;
    r = (l % 16'(m)) + 16'd1;
    return r[4:0];
  endfunction

  task automatic reseed();
    for (int i = 0; i < 2; i++) ma[i] = 16'(i + 1);
    for (int i = 0; i < 4; i++) mb[i] = 16'(i + 1);
    cnt_a = 0;
    cnt_b = 0;
  endtask

  // n = cycles spent in ROLLING; 16 SETTLE cycles, last face update at settle count 12
  task automatic push_a(input int n);
    exp_t e;
    logic [4:0] f;
    e.dice = 20'd0;
    for (int i = 0; i < 2; i++) begin
      f = face(adv(ma[i], n + 12), 6);
      e.dice[i*3 +: 3] = f[2:0];
      ma[i] = adv(ma[i], n + 16);
    end
    cnt_a++;
    e.cnt = 16'(cnt_a);
    qa.push_back(e);
  endtask

  task automatic push_b();
    exp_t e;
    e.dice = 20'd0;
    for (int i = 0; i < 4; i++) begin
      e.dice[i*5 +: 5] = face(adv(mb[i], 4), 20);
      mb[i] = adv(mb[i], 8);
    end
    cnt_b++;
    e.cnt = 16'(cnt_b);
    qb.push_back(e);
  endtask

  task automatic watch_a(input int n, output int rl_n, output int rv_n, output logic [5:0] d_at,
                         output logic [3:0] s_at, output logic [15:0] c_at, output bit rng_ok);
    rl_n = 0; rv_n = 0; d_at = 6'd0; s_at = 4'd0; c_at = 16'd0; rng_ok = 1'b1;
    repeat (n) begin
      @(negedge clk);
      if (rl) rl_n++;
      if (rv) begin rv_n++; d_at = dv; s_at = ds; c_at = rc; end
      if (dv[2:0] < 3'd1 || dv[2:0] > 3'd6 || dv[5:3] < 3'd1 || dv[5:3] > 3'd6) rng_ok = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; button = 1'b0; button_b = 1'b0; mode = 1'b0;
    reseed();
    repeat (3) @(negedge clk);
    tests++;
    if ({dv, ds, rv, rl, rc} !== {6'b001001, 4'd2, 1'b0, 1'b0, 16'd0}) begin
      fails++; $display("FAIL reset_a got dv=%b ds=%0d rv=%b rl=%b rc=%0d want dv=001001 ds=2 0 0 0", dv, ds, rv, rl, rc);
    end
    tests++;
    if ({dv_b, ds_b, rv_b, rl_b, rc_b} !== {{4{5'd1}}, 7'd4, 1'b0, 1'b0, 16'd0}) begin
      fails++; $display("FAIL reset_b got dv=%h ds=%0d rv=%b rl=%b rc=%0d want dv=%h ds=4", dv_b, ds_b, rv_b, rl_b, rc_b, {4{5'd1}});
    end
    reset = 1'b0;
    repeat (5) @(negedge clk);
    tests++;
    if ({dv, ds, rl} !== {6'b001001, 4'd2, 1'b0}) begin
      fails++; $display("FAIL post_reset got dv=%b ds=%0d rl=%b want 001001 2 0", dv, ds, rl);
    end
  endtask

  task automatic test_debounce_glitch();
    int rl_n, rv_n; logic [5:0] d; logic [3:0] s; logic [15:0] c; bit ok;
    @(negedge clk);
    fork
      begin button = 1'b1; repeat (3) @(negedge clk); button = 1'b0; end
      watch_a(30, rl_n, rv_n, d, s, c, ok);
    join
    tests++;
    if (rl_n != 0 || rv_n != 0) begin
      fails++; $display("FAIL glitch_roll got rolling=%0d pulses=%0d want 0 0", rl_n, rv_n);
    end
    tests++;
    if ({dv, ds} !== {6'b001001, 4'd2}) begin
      fails++; $display("FAIL glitch_dice got dv=%b ds=%0d want 001001 2", dv, ds);
    end
  endtask

  task automatic test_timed_roll(input bool_press_again);
    int rl_n, rv_n; logic [5:0] d; logic [3:0] s; logic [15:0] c; bit ok; exp_t e;
    mode = 1'b1;
    push_a(32);
    @(negedge clk);
    fork
      begin
        button = 1'b1; repeat (10) @(negedge clk); button = 1'b0;
        if (bool_press_again) begin
          repeat (35) @(negedge clk); button = 1'b1; repeat (10) @(negedge clk); button = 1'b0;
        end
      end
      watch_a(120, rl_n, rv_n, d, s, c, ok);
    join
    e = qa.pop_front();
    tests++;
    if (rl_n != 48 || rv_n != 1) begin
      fails++; $display("FAIL timed_len again=%0b got rolling=%0d pulses=%0d want 48 1", bool_press_again, rl_n, rv_n);
    end
    tests++;
    if (d !== e.dice[5:0] || c !== e.cnt) begin
      fails++; $display("FAIL timed_result got dv=%b rc=%0d want dv=%b rc=%0d", d, c, e.dice[5:0], e.cnt);
    end
    tests++;
    if (s !== ({1'b0, d[5:3]} + {1'b0, d[2:0]}) || !ok) begin
      fails++; $display("FAIL timed_sum got ds=%0d range_ok=%0b want %0d 1", s, ok, {1'b0, d[5:3]} + {1'b0, d[2:0]});
    end
  endtask

  task automatic test_hold_roll();
    int rl_n, rv_n; logic [5:0] d; logic [3:0] s; logic [15:0] c; bit ok; exp_t e;
    mode = 1'b0;
    push_a(100);
    @(negedge clk);
    fork
      begin button = 1'b1; repeat (100) @(negedge clk); button = 1'b0; end
      watch_a(160, rl_n, rv_n, d, s, c, ok);
    join
    e = qa.pop_front();
    tests++;
    if (rl_n != 116 || rv_n != 1) begin
      fails++; $display("FAIL hold_len got rolling=%0d pulses=%0d want 116 1", rl_n, rv_n);
    end
    tests++;
    if (d !== e.dice[5:0] || c !== e.cnt || !ok) begin
      fails++; $display("FAIL hold_result got dv=%b rc=%0d ok=%0b want dv=%b rc=%0d ok=1", d, c, ok, e.dice[5:0], e.cnt);
    end
    tests++;
    if (s !== ({1'b0, d[5:3]} + {1'b0, d[2:0]})) begin
      fails++; $display("FAIL hold_sum got %0d want %0d", s, {1'b0, d[5:3]} + {1'b0, d[2:0]});
    end
  endtask

  task automatic test_reset_mid_roll();
    int rl_n, rv_n; logic [5:0] d; logic [3:0] s; logic [15:0] c; bit ok; exp_t e;
    mode = 1'b0;
    @(negedge clk);
    button = 1'b1;
    watch_a(20, rl_n, rv_n, d, s, c, ok);
    tests++;
    if (rl_n == 0 || rv_n != 0) begin
      fails++; $display("FAIL pre_abort got rolling=%0d pulses=%0d want >0 0", rl_n, rv_n);
    end
    #2 reset = 1'b1;
    #1;
    tests++;
    if ({dv, ds, rv, rl, rc} !== {6'b001001, 4'd2, 1'b0, 1'b0, 16'd0}) begin
      fails++; $display("FAIL async_reset got dv=%b ds=%0d rv=%b rl=%b rc=%0d want 001001 2 0 0 0", dv, ds, rv, rl, rc);
    end
    watch_a(3, rl_n, rv_n, d, s, c, ok);
    tests++;
    if (rl_n != 0 || rv_n != 0) begin
      fails++; $display("FAIL in_reset got rolling=%0d pulses=%0d want 0 0", rl_n, rv_n);
    end
    reset = 1'b0;
    reseed();
    push_a(20);
    fork
      begin repeat (20) @(negedge clk); button = 1'b0; end
      watch_a(80, rl_n, rv_n, d, s, c, ok);
    join
    e = qa.pop_front();
    tests++;
    if (rl_n != 36 || rv_n != 1) begin
      fails++; $display("FAIL held_through_reset got rolling=%0d pulses=%0d want 36 1", rl_n, rv_n);
    end
    tests++;
    if (d !== e.dice[5:0] || c !== e.cnt || s !== ({1'b0, d[5:3]} + {1'b0, d[2:0]})) begin
      fails++; $display("FAIL post_abort_result got dv=%b rc=%0d ds=%0d want dv=%b rc=%0d", d, c, s, e.dice[5:0], e.cnt);
    end
  endtask

  task automatic test_d20_many();
    logic [20:0] seen;
    exp_t e;
    bit got;
    int sum;
    seen = 21'd0;
    for (int r = 0; r < 1000; r++) begin
      @(negedge clk);
      button_b = 1'b1;
      push_b();
      got = 1'b0;
      for (int k = 0; k < 30 && !got; k++) begin
        @(negedge clk);
        if (k == 1) button_b = 1'b0;
        if (rv_b) begin
          got = 1'b1;
          e = qb.pop_front();
          sum = 0;
          for (int i = 0; i < 4; i++) begin
            sum += int'(dv_b[i*5 +: 5]);
            if (dv_b[i*5 +: 5] >= 5'd1 && dv_b[i*5 +: 5] <= 5'd20) seen[dv_b[i*5 +: 5]] = 1'b1;
          end
          tests++;
          if (dv_b !== e.dice || rc_b !== e.cnt) begin
            fails++; $display("FAIL d20_roll%0d got dv=%h rc=%0d want dv=%h rc=%0d", r, dv_b, rc_b, e.dice, e.cnt);
          end
          tests++;
          if (ds_b !== 7'(sum) || sum > 80) begin
            fails++; $display("FAIL d20_sum%0d got %0d want %0d", r, ds_b, sum);
          end
        end
      end
      if (!got) begin
        tests++; fails++;
        $display("FAIL d20_timeout%0d got no result_valid within 30 cycles want one pulse", r);
        button_b = 1'b0;
      end
      repeat (2) @(negedge clk);
    end
    tests++;
    if (rc_b !== 16'd1000) begin
      fails++; $display("FAIL d20_count got %0d want 1000", rc_b);
    end
    tests++;
    if (seen[20:1] !== 20'hFFFFF) begin
      fails++; $display("FAIL d20_coverage got seen=%h want fffff", seen[20:1]);
    end
  endtask

  initial begin
    test_reset();
    test_debounce_glitch();
    test_timed_roll(1'b0);
    test_timed_roll(1'b1);
    test_hold_roll();
    test_reset_mid_roll();
    test_d20_many();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/multi_dice_roller.md
MULTI_DICE_ROLLER -- requirements
Module: multi_dice_roller

Interface
REQ-001 SHALL have parameter DICE_MAX, default 6: faces per die, legal range 2..255.
REQ-002 SHALL have parameter NUM_DICE, default 2: number of dice, legal range 1..16.
REQ-003 SHALL have parameter DEBOUNCE_CYCLES, default 4: stable cycles required before a button change is accepted, minimum 1.
REQ-004 SHALL have parameter ROLL_CYCLES, default 32: roll length in timed mode, minimum 1.
REQ-005 SHALL have parameter SETTLE_CYCLES, default 16: length of the slow-down phase, minimum 4.
REQ-006 SHALL derive localparams BIT_WIDTH = $clog2(DICE_MAX+1) and SUM_WIDTH = $clog2(NUM_DICE*DICE_MAX+1).
REQ-007 clk  input  1  single clock; all state on rising edge.
REQ-008 reset  input  1  asynchronous, active-high reset.
REQ-009 button  input  1  raw, asynchronous roll request.
REQ-010 mode  input  1  0 = roll while held; 1 = timed roll of ROLL_CYCLES per press; sampled in IDLE only.
REQ-011 dice_values  output  NUM_DICE*BIT_WIDTH  flattened dice; die i at [i*BIT_WIDTH +: BIT_WIDTH].
REQ-012 dice_sum  output  SUM_WIDTH  registered sum of all dice_values.
REQ-013 result_valid  output  1  one-cycle pulse when a final result is presented.
REQ-014 rolling  output  1  high in ROLLING and SETTLE.
REQ-015 roll_count  output  16  number of completed rolls, wraps 65535 -> 0.

Function
REQ-016 SHALL synchronise button through two flops, then debounce: btn_db takes the synchronised value only after it differs from btn_db for DEBOUNCE_CYCLES consecutive cycles; any match restarts the count.
REQ-017 SHALL define press as a 0->1 transition of btn_db and release as a 1->0 transition of btn_db.
REQ-018 SHALL implement FSM states IDLE, ROLLING, SETTLE, DONE.
REQ-019 IDLE -> ROLLING on press; mode is latched in the same cycle.
REQ-020 ROLLING, mode 0: -> SETTLE on release.
REQ-021 ROLLING, mode 1: -> SETTLE after exactly ROLL_CYCLES cycles in ROLLING; button ignored.
REQ-022 SETTLE -> DONE after exactly SETTLE_CYCLES cycles.
REQ-023 DONE lasts one cycle, then -> IDLE; result_valid = 1 and roll_count increments in that cycle.
REQ-024 SHALL ignore presses in SETTLE and DONE; a new roll requires btn_db low in IDLE followed by a new press.
REQ-025 SHALL keep one 16-bit Fibonacci LFSR per die, taps 16,14,13,11, shifting right with the feedback bit inserted at bit 15; LFSR i seeds to i+1.
REQ-026 SHALL advance every LFSR once per cycle in ROLLING and SETTLE; they hold in IDLE and DONE.
REQ-027 In ROLLING, each die SHALL update every cycle to (lfsr_i % DICE_MAX) + 1, using the pre-shift LFSR value.
REQ-028 In SETTLE, dice SHALL update only on cycles where the settle counter (0-based) is a multiple of 4, using the same mapping.
REQ-029 dice_values SHALL hold constant outside ROLLING and SETTLE; every die SHALL always be within 1..DICE_MAX.
REQ-030 dice_sum SHALL equal the sum of the dice_values present one cycle earlier (one-cycle latency), with no overflow at SUM_WIDTH.
REQ-031 The final dice update SHALL occur no later than the last SETTLE cycle, so dice_sum is consistent with dice_values when result_valid = 1.

Reset
REQ-032 On reset high, regardless of clk: FSM = IDLE, LFSRs = seeds, every die = 1, dice_sum = NUM_DICE, result_valid = 0, rolling = 0, roll_count = 0, synchronisers, btn_db and debounce counter = 0.
REQ-033 Reset asserted mid-roll SHALL abort with no result_valid pulse; a button still held at release of reset SHALL be treated as a new press once debounced.

Verification
REQ-034 Reset with defaults -> dice_values = {3'd1,3'd1}, dice_sum = 2, result_valid = 0, roll_count = 0.
REQ-035 Button high for 3 cycles (less than DEBOUNCE_CYCLES = 4) -> rolling stays 0 and dice_values unchanged.
REQ-036 mode 0, button held 100 cycles then released -> rolling high until release is debounced plus 16 SETTLE cycles; one result_valid pulse; dice in 1..6; dice_sum equals their sum; roll_count = 1.
REQ-037 mode 1, button pulsed 10 cycles -> exactly 32 ROLLING + 16 SETTLE cycles; one result_valid pulse; pressing again during SETTLE produces no second roll.
REQ-038 Reset asserted during ROLLING -> outputs return to REQ-032 values with no result_valid pulse.
REQ-039 DICE_MAX = 20, NUM_DICE = 4, 1000 rolls -> every die in 1..20, dice_sum <= 80, roll_count = 1000, each die value seen at least once.
